// File: rtl/pi_alu_seq.sv
// Microprogram sequencer and operand register file for the shared 16-bit PI-control ALU.
// Optional build macro PI_ANTIWINDUP_EN freezes the integrator after a saturated iteration.
module pi_alu_seq #(
    parameter int MUL_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [11:0]        setpoint,
    input  logic [11:0]        A2D_res,
    input  logic [13:0]        Pterm,
    input  logic signed [11:0] Iterm,
    input  logic [11:0]        Fwd,
    input  logic [15:0]        dst,
    output logic [2:0]         src1sel,
    output logic [2:0]         src0sel,
    output logic               multiply,
    output logic               sub,
    output logic               saturate,
    output logic               mult2,
    output logic               mult4,
    output logic [15:0]        Accum,
    output logic [15:0]        Pcomp,
    output logic signed [11:0] Error,
    output logic signed [11:0] Intgrl,
    output logic signed [11:0] Icomp,
    output logic               busy,
    output logic               done,
    output logic signed [11:0] drive,
    output logic               sat
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ERR, INTG, ICMP, PCMP, ACC1, ACC2, DONE} state_t;

    typedef struct packed {
        logic [2:0] s1;
        logic [2:0] s0;
        logic       mul;
        logic       sb;
        logic       st;
    } ctrl_t;

    state_t           state;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] cnt;

    // The ALU reads these operands straight from the input bus; they pass through here only.
    logic unused_ops;
    assign unused_ops = ^{A2D_res, Pterm, Iterm, Fwd};

    function automatic ctrl_t step_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ERR:  begin c.sb = 1'b1; c.st = 1'b1; end
            INTG: begin c.s1 = 3'd3; c.s0 = 3'd1; c.st = 1'b1; end
            ICMP: begin c.s1 = 3'd1; c.s0 = 3'd1; c.mul = 1'b1; end
            PCMP: begin c.s1 = 3'd2; c.s0 = 3'd4; c.mul = 1'b1; end
            ACC1: begin c.s1 = 3'd4; c.s0 = 3'd3; end
            ACC2: begin c.s1 = 3'd0; c.s0 = 3'd2; c.st = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic at_rail(input logic [15:0] v);
        return (v == 16'h07FF) || (v == 16'h0800);
    endfunction

    assign src1sel  = ctrl.s1;
    assign src0sel  = ctrl.s0;
    assign multiply = ctrl.mul;
    assign sub      = ctrl.sb;
    assign saturate = ctrl.st;
    assign mult2    = 1'b0;
    assign mult4    = 1'b0;

    // Controls are registered on step entry so they stay constant for the whole step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ctrl   <= '0;
            cnt    <= '0;
            Accum  <= '0;
            Pcomp  <= '0;
            Error  <= '0;
            Intgrl <= '0;
            Icomp  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            drive  <= '0;
            sat    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        Accum <= {4'b0000, setpoint};
                        busy  <= 1'b1;
                        state <= ERR;
                        ctrl  <= step_ctrl(ERR);
                    end
                end
                ERR: begin
                    Error <= dst[11:0];
                    state <= INTG;
                    ctrl  <= step_ctrl(INTG);
                end
                INTG: begin
`ifdef PI_ANTIWINDUP_EN
                    if (!sat) Intgrl <= dst[11:0];
`else
                    Intgrl <= dst[11:0];
`endif
                    cnt   <= MUL_LOAD;
                    state <= ICMP;
                    ctrl  <= step_ctrl(ICMP);
                end
                ICMP: begin
                    if (cnt == '0) begin
                        Icomp <= dst[11:0];
                        cnt   <= MUL_LOAD;
                        state <= PCMP;
                        ctrl  <= step_ctrl(PCMP);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PCMP: begin
                    if (cnt == '0) begin
                        Pcomp <= dst;
                        state <= ACC1;
                        ctrl  <= step_ctrl(ACC1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACC1: begin
                    Accum <= dst;
                    state <= ACC2;
                    ctrl  <= step_ctrl(ACC2);
                end
                ACC2: begin
                    // Publish straight from dst so drive is already valid while done is high.
                    Accum <= dst;
                    drive <= dst[11:0];
                    sat   <= at_rail(dst);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                    ctrl  <= '0;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ctrl  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pi_alu_seq.sv
// Directed bench for pi_alu_seq: a behavioural ALU closes the loop for two instances
// (MUL_CYCLES=2 and MUL_CYCLES=4); expected values are hand-computed constants.
module tb_pi_alu_seq;

    logic               clk;
    logic               rst_n;
    logic               go;
    logic [11:0]        setpoint;
    logic [11:0]        A2D_res;
    logic [13:0]        Pterm;
    logic signed [11:0] Iterm;
    logic [11:0]        Fwd;

    logic [15:0]        dst, dst4;
    logic [2:0]         src1sel, src0sel, src1sel4, src0sel4;
    logic               multiply, sub, saturate, mult2, mult4;
    logic               multiply4, sub4, saturate4, mult2_4, mult4_4;
    logic [15:0]        Accum, Pcomp, Accum4, Pcomp4;
    logic signed [11:0] Error, Intgrl, Icomp, Error4, Intgrl4, Icomp4;
    logic               busy, done, sat, busy4, done4, sat4;
    logic signed [11:0] drive, drive4;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [8:0] EXP4 [12] = '{
        9'b000000011, 9'b011001001,
        9'b001001100, 9'b001001100, 9'b001001100, 9'b001001100,
        9'b010100100, 9'b010100100, 9'b010100100, 9'b010100100,
        9'b100011000, 9'b000010001
    };

    // Behavioural ALU: src1 {Accum, Iterm, Error, Error>>>4, Fwd}, src0 {A2D, Intgrl, Icomp, Pcomp, Pterm}.
    function automatic logic [15:0] alu(
        input logic [2:0] s1, input logic [2:0] s0,
        input logic mul, input logic sb, input logic st,
        input logic [15:0] acc, input logic [15:0] pc,
        input logic [11:0] err, input logic [11:0] intg, input logic [11:0] icmp,
        input logic [11:0] a2d, input logic [13:0] pt, input logic [11:0] it, input logic [11:0] fw);
        logic signed [15:0] a, b, bb;
        logic signed [31:0] p;
        logic signed [16:0] sum;
        logic [15:0]        r;
        case (s1)
            3'd0: a = acc;
            3'd1: a = {{4{it[11]}}, it};
            3'd2: a = {{4{err[11]}}, err};
            3'd3: begin a = {{4{err[11]}}, err}; a = a >>> 4; end
            3'd4: a = {4'b0000, fw};
            default: a = '0;
        endcase
        case (s0)
            3'd0: b = {4'b0000, a2d};
            3'd1: b = {{4{intg[11]}}, intg};
            3'd2: b = {{4{icmp[11]}}, icmp};
            3'd3: b = pc;
            3'd4: b = {2'b00, pt};
            default: b = '0;
        endcase
        if (mul) begin
            p = a * b;
            r = p[15:0];
        end else begin
            bb  = sb ? ~b : b;
            sum = {a[15], a} + {bb[15], bb};
            r   = sum[15:0];
            if (st) begin
                if (sum > 17'sd2047)       r = 16'h07FF;
                else if (sum < -17'sd2048) r = 16'h0800;
            end
        end
        return r;
    endfunction

    assign dst  = alu(src1sel, src0sel, multiply, sub, saturate, Accum, Pcomp,
                      Error, Intgrl, Icomp, A2D_res, Pterm, Iterm, Fwd);
    assign dst4 = alu(src1sel4, src0sel4, multiply4, sub4, saturate4, Accum4, Pcomp4,
                      Error4, Intgrl4, Icomp4, A2D_res, Pterm, Iterm, Fwd);

    pi_alu_seq #(.MUL_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .go(go), .setpoint(setpoint), .A2D_res(A2D_res),
        .Pterm(Pterm), .Iterm(Iterm), .Fwd(Fwd), .dst(dst),
        .src1sel(src1sel), .src0sel(src0sel), .multiply(multiply), .sub(sub),
        .saturate(saturate), .mult2(mult2), .mult4(mult4),
        .Accum(Accum), .Pcomp(Pcomp), .Error(Error), .Intgrl(Intgrl), .Icomp(Icomp),
        .busy(busy), .done(done), .drive(drive), .sat(sat)
    );

    pi_alu_seq #(.MUL_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .go(go), .setpoint(setpoint), .A2D_res(A2D_res),
        .Pterm(Pterm), .Iterm(Iterm), .Fwd(Fwd), .dst(dst4),
        .src1sel(src1sel4), .src0sel(src0sel4), .multiply(multiply4), .sub(sub4),
        .saturate(saturate4), .mult2(mult2_4), .mult4(mult4_4),
        .Accum(Accum4), .Pcomp(Pcomp4), .Error(Error4), .Intgrl(Intgrl4), .Icomp(Icomp4),
        .busy(busy4), .done(done4), .drive(drive4), .sat(sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [11:0] sp, input logic [11:0] a2d,
                          input logic [13:0] pt, input logic [11:0] it, input logic [11:0] fw);
        setpoint = sp; A2D_res = a2d; Pterm = pt; Iterm = it; Fwd = fw;
    endtask

    // Launches one iteration on the MUL_CYCLES=2 instance; returns edges to done and busy cycles.
    task automatic run_iter(output int lat, output int bcnt);
        go = 1'b1;
        tick();
        go = 1'b0;
        lat  = 0;
        bcnt = int'(busy);
        while (!done && lat < 40) begin
            tick();
            lat++;
            bcnt += int'(busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        go    = 1'b1;
        set_in(12'h200, 12'h100, 14'h0, 12'h0, 12'h0);
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++;
            $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        n_cmp++; if ({Accum, Pcomp} !== 32'h0) begin n_bad++;
            $display("FAIL reset_accum_pcomp: got %h %h want 0 0", Accum, Pcomp); end
        n_cmp++; if ({Error, Intgrl, Icomp} !== 36'h0) begin n_bad++;
            $display("FAIL reset_operands: got %h %h %h want 0 0 0", Error, Intgrl, Icomp); end
        n_cmp++; if ({drive, sat} !== 13'h0) begin n_bad++;
            $display("FAIL reset_drive_sat: got %h %b want 0 0", drive, sat); end
        n_cmp++; if ({src1sel, src0sel, multiply, sub, saturate, mult2, mult4} !== 11'h0) begin n_bad++;
            $display("FAIL reset_ctrl: got %b want 0", {src1sel, src0sel, multiply, sub, saturate, mult2, mult4}); end
        go    = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL reset_idle_after: busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        set_in(12'h200, 12'h100, 14'h0, 12'h0, 12'h0);
        run_iter(lat, bcnt);
        n_cmp++; if (lat !== 8) begin n_bad++;
            $display("FAIL basic_latency: got %0d want 8", lat); end
        n_cmp++; if (bcnt !== 8) begin n_bad++;
            $display("FAIL basic_busy_cycles: got %0d want 8", bcnt); end
        n_cmp++; if (Error !== 12'h0FF) begin n_bad++;
            $display("FAIL basic_error: got %h want 0ff", Error); end
        n_cmp++; if (Intgrl !== 12'h00F) begin n_bad++;
            $display("FAIL basic_intgrl: got %h want 00f", Intgrl); end
        n_cmp++; if (drive !== 12'h000 || sat !== 1'b0) begin n_bad++;
            $display("FAIL basic_drive: got %h sat %b want 000 sat 0", drive, sat); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++;
            $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_repeat();
        int lat, bcnt;
        run_iter(lat, bcnt);
        tick();
        n_cmp++; if (Intgrl !== 12'h01E || Error !== 12'h0FF) begin n_bad++;
            $display("FAIL repeat_intgrl: got %h err %h want 01e err 0ff", Intgrl, Error); end
    endtask

    task automatic test_pgain();
        int lat, bcnt;
        set_in(12'h200, 12'h100, 14'd2, 12'h0, 12'h0);
        run_iter(lat, bcnt);
        n_cmp++; if (Pcomp !== 16'h01FE) begin n_bad++;
            $display("FAIL pgain_pcomp: got %h want 01fe", Pcomp); end
        n_cmp++; if (Intgrl !== 12'h02D) begin n_bad++;
            $display("FAIL pgain_intgrl: got %h want 02d", Intgrl); end
        n_cmp++; if (drive !== 12'h1FE || sat !== 1'b0) begin n_bad++;
            $display("FAIL pgain_drive: got %h sat %b want 1fe sat 0", drive, sat); end
        tick();
    endtask

    task automatic test_neg_rail();
        int lat, bcnt;
        set_in(12'h100, 12'h200, 14'h10, 12'h0, 12'h0);
        run_iter(lat, bcnt);
        n_cmp++; if (Error !== 12'hEFF) begin n_bad++;
            $display("FAIL neg_error: got %h want eff", Error); end
        n_cmp++; if (Intgrl !== 12'h01C) begin n_bad++;
            $display("FAIL neg_intgrl: got %h want 01c", Intgrl); end
        n_cmp++; if (Pcomp !== 16'hEFF0) begin n_bad++;
            $display("FAIL neg_pcomp: got %h want eff0", Pcomp); end
        n_cmp++; if (drive !== 12'h800 || sat !== 1'b1) begin n_bad++;
            $display("FAIL neg_rail: got %h sat %b want 800 sat 1", drive, sat); end
        tick();
    endtask

    task automatic test_antiwindup();
        int lat, bcnt;
        logic [11:0] exp_a, exp_b;
`ifdef PI_ANTIWINDUP_EN
        exp_a = 12'h01C; exp_b = 12'h01C;
`else
        exp_a = 12'h02B; exp_b = 12'h03A;
`endif
        set_in(12'h200, 12'h100, 14'h0, 12'h001, 12'h7FF);
        run_iter(lat, bcnt);
        n_cmp++; if (Intgrl !== exp_a || Icomp !== exp_a) begin n_bad++;
            $display("FAIL aw_first_intgrl: got %h icomp %h want %h", Intgrl, Icomp, exp_a); end
        n_cmp++; if (drive !== 12'h7FF || sat !== 1'b1) begin n_bad++;
            $display("FAIL aw_pos_rail: got %h sat %b want 7ff sat 1", drive, sat); end
        tick();
        run_iter(lat, bcnt);
        n_cmp++; if (Intgrl !== exp_b || Icomp !== exp_b) begin n_bad++;
            $display("FAIL aw_second_intgrl: got %h icomp %h want %h", Intgrl, Icomp, exp_b); end
        n_cmp++; if (drive !== 12'h7FF || sat !== 1'b1) begin n_bad++;
            $display("FAIL aw_second_rail: got %h sat %b want 7ff sat 1", drive, sat); end
        tick();
    endtask

    task automatic test_go_while_busy();
        int ndone;
        set_in(12'h200, 12'h100, 14'h0, 12'h0, 12'h0);
        go    = 1'b1;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            ndone += int'(done);
            go = (i == 1 || i == 3 || i == 5 || i == 8);
        end
        n_cmp++; if (ndone !== 1) begin n_bad++;
            $display("FAIL busy_pulsed_go: got %0d done pulses want 1", ndone); end
        go    = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            ndone += int'(done);
        end
        go = 1'b0;
        n_cmp++; if (ndone !== 2) begin n_bad++;
            $display("FAIL busy_held_go: got %0d done pulses want 2", ndone); end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ndone += int'(done);
        end
        n_cmp++; if (ndone !== 0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL busy_drain: got %0d pulses busy %b want 0 busy 0", ndone, busy); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        set_in(12'h200, 12'h100, 14'h0, 12'h0, 12'h0);
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (5) tick();
        n_cmp++; if (busy !== 1'b1 || Error !== 12'h0FF) begin n_bad++;
            $display("FAIL midrst_pre: got busy %b err %h want 1 0ff", busy, Error); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++;
            $display("FAIL midrst_busy: got busy %b done %b want 0 0", busy, done); end
        n_cmp++; if ({Error, Intgrl, Accum} !== 40'h0) begin n_bad++;
            $display("FAIL midrst_operands: got %h %h %h want 0", Error, Intgrl, Accum); end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ndone += int'(done);
        end
        n_cmp++; if (ndone !== 0) begin n_bad++;
            $display("FAIL midrst_no_done: got %0d pulses want 0", ndone); end
    endtask

    task automatic test_mul4();
        int early, bcnt;
        set_in(12'h200, 12'h100, 14'd2, 12'h0, 12'h0);
        go    = 1'b1;
        early = 0;
        bcnt  = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 0) go = 1'b0;
            early += int'(done4);
            bcnt  += int'(busy4);
            n_cmp++;
            if ({src1sel4, src0sel4, multiply4, sub4, saturate4} !== EXP4[k]) begin n_bad++;
                $display("FAIL mul4_ctrl_%0d: got %b want %b", k,
                         {src1sel4, src0sel4, multiply4, sub4, saturate4}, EXP4[k]); end
        end
        tick();
        n_cmp++; if (done4 !== 1'b1 || early !== 0) begin n_bad++;
            $display("FAIL mul4_latency: got done %b early %0d want done 1 early 0", done4, early); end
        n_cmp++; if (bcnt !== 12 || busy4 !== 1'b0) begin n_bad++;
            $display("FAIL mul4_busy: got %0d busy %b want 12 busy 0", bcnt, busy4); end
        n_cmp++; if (Error4 !== 12'h0FF || Intgrl4 !== 12'h00F || Pcomp4 !== 16'h01FE) begin n_bad++;
            $display("FAIL mul4_operands: got %h %h %h want 0ff 00f 01fe", Error4, Intgrl4, Pcomp4); end
        n_cmp++; if (drive4 !== 12'h1FE || sat4 !== 1'b0) begin n_bad++;
            $display("FAIL mul4_drive: got %h sat %b want 1fe sat 0", drive4, sat4); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        set_in(12'h0, 12'h0, 14'h0, 12'h0, 12'h0);
        test_reset();
        test_basic();
        test_repeat();
        test_pgain();
        test_neg_rail();
        test_antiwindup();
        test_go_while_busy();
        test_reset_mid();
        test_mul4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
